ps2_key_decoder: RTL and testbench

- Parametrised PS/2 keyboard receiver with scan-code-set-2 make/break decoding.
- Oversamples PS2_CLK/PS2_DATA on a divided tick and validates each 11-bit frame (start, parity, stop, timeout).
- Folds E0/F0 prefixes into one event per key action and buffers events in a small FIFO with a valid/ready handshake.
- Holds a level-sensitive pressed state for the four arrow keys, which the game controller uses directly.

---
 rtl/ps2_key_decoder.sv | 227 ++++++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver. It decodes scan-code-set-2 make/break events into a small FIFO
// and keeps a held-state vector for the four arrow keys.
module ps2_key_decoder #(
  parameter int CLK_DIV       = 250,
  parameter int TIMEOUT_TICKS = 4000,
  parameter int FIFO_DEPTH    = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic       EVT_VALID,
  input  logic       EVT_READY,
  output logic [7:0] EVT_CODE,
  output logic       EVT_EXT,
  output logic       EVT_BREAK,
  output logic [3:0] KEY_STATE,
  output logic       FRAME_ERR,
  output logic       OVERFLOW
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_TICKS - 1);
  localparam logic [CNT_W-1:0] DEPTH     = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} frame_state_t;

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   ps2_clk_s, ps2_data_s, prev_clk, tick, fall;
  logic [DIV_W-1:0]       div_cnt;

  frame_state_t     state;
  logic [10:0]      frame;
  logic [3:0]       bitcnt;
  logic [TO_W-1:0]  idle_cnt;
  logic             byte_vld, frame_bad;
  logic [7:0]       rx_byte;

  logic             ext, brk, emit, emit_ext, emit_brk;
  logic [7:0]       emit_code;

  logic [9:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_next;
  logic [CNT_W-1:0] count, count_n;
  logic             pop, full, push_ok, head_load;
  logic [9:0]       push_data, head_next;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], PS2_CLK};
      data_sync <= {data_sync[SYNC_STAGES-2:0], PS2_DATA};
    end
  end

  assign ps2_clk_s  = clk_sync[SYNC_STAGES-1];
  assign ps2_data_s = data_sync[SYNC_STAGES-1];
  assign tick       = (div_cnt == DIV_LAST);
  assign fall       = tick & prev_clk & ~ps2_clk_s;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_cnt  <= '0;
      prev_clk <= 1'b1;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) prev_clk <= ps2_clk_s;
    end
  end

  // Frame FSM: bits arrive LSB-first, so after 11 shifts frame[0] is the start bit.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      frame     <= '0;
      bitcnt    <= '0;
      idle_cnt  <= '0;
      byte_vld  <= 1'b0;
      frame_bad <= 1'b0;
      rx_byte   <= '0;
      FRAME_ERR <= 1'b0;
    end else begin
      byte_vld  <= 1'b0;
      frame_bad <= 1'b0;
      FRAME_ERR <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: begin
            if (fall) begin
              frame    <= {ps2_data_s, frame[10:1]};
              bitcnt   <= 4'd1;
              idle_cnt <= '0;
              state    <= SHIFT;
            end
          end
          SHIFT: begin
            if (fall) begin
              frame    <= {ps2_data_s, frame[10:1]};
              bitcnt   <= bitcnt + 4'd1;
              idle_cnt <= '0;
              if (bitcnt == 4'd10) state <= CHECK;
            end else if (idle_cnt == TO_LAST) begin
              FRAME_ERR <= 1'b1;
              bitcnt    <= '0;
              state     <= IDLE;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
          CHECK: begin
            if (!frame[0] && frame[10] && (^frame[9:1])) begin
              byte_vld <= 1'b1;
              rx_byte  <= frame[8:1];
            end else begin
              FRAME_ERR <= 1'b1;
              frame_bad <= 1'b1;
            end
            bitcnt <= '0;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Prefix folding: E0/F0 only set flags, any other byte emits one event.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ext       <= 1'b0;
      brk       <= 1'b0;
      emit      <= 1'b0;
      emit_code <= '0;
      emit_ext  <= 1'b0;
      emit_brk  <= 1'b0;
    end else begin
      emit <= 1'b0;
      if (frame_bad) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (byte_vld) begin
        case (rx_byte)
          8'hE0: ext <= 1'b1;
          8'hF0: brk <= 1'b1;
          default: begin
            emit      <= 1'b1;
            emit_code <= rx_byte;
            emit_ext  <= ext;
            emit_brk  <= brk;
            ext       <= 1'b0;
            brk       <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      KEY_STATE <= '0;
    end else if (emit) begin
      case (emit_code)
        8'h75: KEY_STATE[3] <= ~emit_brk;
        8'h72: KEY_STATE[2] <= ~emit_brk;
        8'h74: KEY_STATE[1] <= ~emit_brk;
        8'h6B: KEY_STATE[0] <= ~emit_brk;
        default: ;
      endcase
    end
  end

  assign push_data = {emit_code, emit_ext, emit_brk};
  assign pop       = EVT_VALID & EVT_READY;
  assign full      = (count == DEPTH);
  assign push_ok   = emit & (~full | pop);
  assign rd_next   = rd_ptr + 1'b1;

  // Head registers preload the entry that will be at the front after this CLK.
  always_comb begin
    count_n   = count;
    head_load = 1'b0;
    head_next = push_data;
    if (push_ok && !pop)      count_n = count + 1'b1;
    else if (pop && !push_ok) count_n = count - 1'b1;
    if (pop) begin
      if (count == CNT_ONE) begin
        head_load = push_ok;
      end else begin
        head_load = 1'b1;
        head_next = mem[rd_next];
      end
    end else if (count == '0 && push_ok) begin
      head_load = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      EVT_VALID <= 1'b0;
      EVT_CODE  <= '0;
      EVT_EXT   <= 1'b0;
      EVT_BREAK <= 1'b0;
      OVERFLOW  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_next;
      if (emit && full && !pop) OVERFLOW <= 1'b1;
      count     <= count_n;
      EVT_VALID <= (count_n != '0);
      if (head_load) {EVT_CODE, EVT_EXT, EVT_BREAK} <= head_next;
    end
  end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: bit-banged PS/2 frames with hand-computed expectations.
module tb_ps2_key_decoder;
  localparam int CLK_DIV = 4;
  localparam int TIMEOUT_TICKS = 64;
  localparam int FIFO_DEPTH = 4;
  localparam int HALF = 4 * CLK_DIV;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DATA = 1'b1;
  logic       EVT_READY = 1'b1;
  logic       EVT_VALID, EVT_EXT, EVT_BREAK, FRAME_ERR, OVERFLOW;
  logic [7:0] EVT_CODE;
  logic [3:0] KEY_STATE;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  logic [9:0] ev_q[$];
  logic [7:0] fill_codes [5] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24};

  ps2_key_decoder #(
    .CLK_DIV(CLK_DIV), .TIMEOUT_TICKS(TIMEOUT_TICKS), .FIFO_DEPTH(FIFO_DEPTH), .SYNC_STAGES(2)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
    .EVT_VALID(EVT_VALID), .EVT_READY(EVT_READY), .EVT_CODE(EVT_CODE),
    .EVT_EXT(EVT_EXT), .EVT_BREAK(EVT_BREAK), .KEY_STATE(KEY_STATE),
    .FRAME_ERR(FRAME_ERR), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  // Observe on the falling edge; a handshake seen here completes at the next rising edge.
  always @(negedge CLK) begin
    if (FRAME_ERR) err_pulses++;
    if (EVT_VALID && EVT_READY) ev_q.push_back({EVT_CODE, EVT_EXT, EVT_BREAK});
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ev_at(int i);
    if (i >= ev_q.size()) return 32'hFFFF_FFFF;
    return 32'(ev_q[i]);
  endfunction

  function automatic logic [31:0] mk(logic [7:0] code, logic e, logic b);
    return 32'({code, e, b});
  endfunction

  task automatic wait_clks(int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_bit(logic b);
    PS2_DATA = b;
    wait_clks(HALF);
    PS2_CLK = 1'b0;
    wait_clks(HALF);
    PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(logic [7:0] d, logic bad_par);
    logic par;
    par = (~^d) ^ bad_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(1'b1);
    PS2_DATA = 1'b1;
    wait_clks(20 * CLK_DIV);
  endtask

  initial begin
    wait_clks(10);
    chk("rst_valid", 32'(EVT_VALID), 32'd0);
    chk("rst_keys", 32'(KEY_STATE), 32'd0);
    chk("rst_err", 32'(FRAME_ERR), 32'd0);
    chk("rst_ovf", 32'(OVERFLOW), 32'd0);
    chk("rst_code", 32'(EVT_CODE), 32'd0);
    RST_N = 1'b1;

    wait_clks(10000 * CLK_DIV);
    chk("idle_valid", 32'(EVT_VALID), 32'd0);
    chk("idle_keys", 32'(KEY_STATE), 32'd0);
    chk("idle_errs", 32'(err_pulses), 32'd0);
    chk("idle_events", 32'(ev_q.size()), 32'd0);

    send_frame(8'h75, 1'b0);
    chk("up_make_n", 32'(ev_q.size()), 32'd1);
    chk("up_make_ev", ev_at(0), mk(8'h75, 1'b0, 1'b0));
    chk("up_make_keys", 32'(KEY_STATE), 32'b1000);
    ev_q.delete();

    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    chk("up_ext_brk_n", 32'(ev_q.size()), 32'd1);
    chk("up_ext_brk_ev", ev_at(0), mk(8'h75, 1'b1, 1'b1));
    chk("up_ext_brk_keys", 32'(KEY_STATE), 32'b0000);
    ev_q.delete();

    send_frame(8'h6B, 1'b0);
    chk("left_make_ev", ev_at(0), mk(8'h6B, 1'b0, 1'b0));
    chk("left_make_keys", 32'(KEY_STATE), 32'b0001);
    ev_q.delete();
    send_frame(8'h6B, 1'b1);
    chk("par_err_pulses", 32'(err_pulses), 32'd1);
    chk("par_err_events", 32'(ev_q.size()), 32'd0);
    chk("par_err_keys", 32'(KEY_STATE), 32'b0001);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h6B, 1'b0);
    chk("left_brk_n", 32'(ev_q.size()), 32'd1);
    chk("left_brk_ev", ev_at(0), mk(8'h6B, 1'b0, 1'b1));
    chk("left_brk_keys", 32'(KEY_STATE), 32'b0000);
    ev_q.delete();

    for (int i = 0; i < 7; i++) send_bit(1'b0);
    PS2_DATA = 1'b1;
    wait_clks((TIMEOUT_TICKS + 10) * CLK_DIV);
    chk("timeout_pulses", 32'(err_pulses), 32'd2);
    chk("timeout_events", 32'(ev_q.size()), 32'd0);
    send_frame(8'h72, 1'b0);
    chk("down_n", 32'(ev_q.size()), 32'd1);
    chk("down_ev", ev_at(0), mk(8'h72, 1'b0, 1'b0));
    chk("down_keys", 32'(KEY_STATE), 32'b0100);
    ev_q.delete();

    EVT_READY = 1'b0;
    for (int i = 0; i < 5; i++) send_frame(fill_codes[i], 1'b0);
    chk("fill_valid", 32'(EVT_VALID), 32'd1);
    chk("fill_head_held", 32'(EVT_CODE), 32'h1C);
    chk("fill_ovf", 32'(OVERFLOW), 32'd1);
    chk("fill_no_pops", 32'(ev_q.size()), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", 32'(EVT_VALID), 32'd1);
      chk("drain_head", 32'(EVT_CODE), 32'(fill_codes[i]));
      wait_clks(3);
      chk("drain_head_stable", {22'd0, EVT_CODE, EVT_EXT, EVT_BREAK}, mk(fill_codes[i], 1'b0, 1'b0));
      EVT_READY = 1'b1;
      wait_clks(1);
      EVT_READY = 1'b0;
      wait_clks(2);
    end
    chk("drain_empty", 32'(EVT_VALID), 32'd0);
    chk("drain_ovf_sticky", 32'(OVERFLOW), 32'd1);
    chk("drain_n", 32'(ev_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("drain_order", ev_at(i), mk(fill_codes[i], 1'b0, 1'b0));
    chk("drain_keys", 32'(KEY_STATE), 32'b0100);
    chk("final_errs", 32'(err_pulses), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
